// File: rtl/brisc_pkg.sv
// Shared core types and constants.
// Writeback entry layout and arbiter selectors.
package brisc_pkg;

  localparam int XLEN     = 32;
  localparam int REG_BITS = 5;

  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_MEM = 1;
  localparam int WB_SRC_MUL = 2;
  localparam int WB_NUM_SRC = 3;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef struct packed {
    logic [REG_BITS-1:0] rd;
    logic [XLEN-1:0]     data;
    logic                wen;
  } wb_entry_t;

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result FIFO for the writeback arbiter.
// Circular buffer; pointers wrap explicitly so any DEPTH works.
module wb_src_fifo
  import brisc_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  wb_entry_t     wr_entry,
  input  logic          pop,
  output wb_entry_t     head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        if (wr_ptr == PW'(DEPTH - 1)) wr_ptr <= '0;
        else                          wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        if (rd_ptr == PW'(DEPTH - 1)) rd_ptr <= '0;
        else                          rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Multi-source writeback: per-source FIFOs, one retire per cycle.
// Registered output also serves as the forwarding source.
module wb_arbiter
  import brisc_pkg::*;
#(
  parameter int NUM_SRC  = WB_NUM_SRC,
  parameter int DEPTH    = 2,
  parameter int ARB_MODE = ARB_RR,
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC-1:0]          src_valid_in,
  output logic [NUM_SRC-1:0]          src_ready_out,
  input  logic [NUM_SRC*REG_BITS-1:0] src_rd_in,
  input  logic [NUM_SRC*XLEN-1:0]     src_data_in,
  input  logic [NUM_SRC-1:0]          src_wen_in,
  output logic                        retire_valid_out,
  output logic [SW-1:0]               retire_src_out,
  output logic [REG_BITS-1:0]         rd_out,
  output logic [XLEN-1:0]             rd_data_out,
  output logic                        write_rf,
  output logic                        busy_out
);

  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t        wr_entry [NUM_SRC];
  wb_entry_t        head     [NUM_SRC];
  logic [CW-1:0]    count    [NUM_SRC];
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;

  logic          grant_any;
  logic [SW-1:0] grant_idx;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] rr_next;
  wb_entry_t     head_sel;
  int            j;

  assign src_ready_out = ~full;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign wr_entry[g] = '{
      rd:   src_rd_in[g*REG_BITS +: REG_BITS],
      data: src_data_in[g*XLEN +: XLEN],
      wen:  src_wen_in[g]
    };
    assign push[g] = src_valid_in[g] && !full[g];
    assign pop[g]  = grant_any && (grant_idx == SW'(g));

    wb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push[g]),
      .wr_entry (wr_entry[g]),
      .pop      (pop[g]),
      .head     (head[g]),
      .count    (count[g]),
      .full     (full[g]),
      .empty    (empty[g])
    );
  end

  // Busy while any FIFO holds an entry.
  always_comb begin
    busy_out = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (count[i] != '0) busy_out = 1'b1;
    end
  end

  // Pick the first non-empty head from the search start.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    j         = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (ARB_MODE == ARB_FIXED) j = k;
      else                       j = (int'(rr_ptr) + k) % NUM_SRC;
      if (!grant_any && !empty[j]) begin
        grant_any = 1'b1;
        grant_idx = SW'(j);
      end
    end
  end

  assign head_sel = head[grant_idx];
  assign rr_next  = (grant_idx == SW'(NUM_SRC - 1)) ? '0
                  : grant_idx + 1'b1;

  // Round-robin pointer moves past the winner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= rr_next;
    end
  end

  // Retire register; address/data hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_valid_out <= 1'b0;
      retire_src_out   <= '0;
      rd_out           <= '0;
      rd_data_out      <= '0;
      write_rf         <= 1'b0;
    end else begin
      retire_valid_out <= grant_any;
      retire_src_out   <= grant_idx;
      write_rf         <= grant_any && head_sel.wen
                          && (head_sel.rd != '0);
      if (grant_any) begin
        rd_out      <= head_sel.rd;
        rd_data_out <= head_sel.data;
      end
    end
  end

endmodule
